// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM encoding and write-strobe run decoding for the SPI RAM controller.
package spi_ram_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StHold,
        StGap,
        StResp
    } state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] start;
        logic [2:0] len;
    } run_t;

    // First maximal run of set strobe bits at or above byte position 'from'.
    function automatic run_t next_run(input logic [3:0] strb, input logic [2:0] from);
        run_t r;
        logic open;
        r    = '0;
        open = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) >= from && strb[i]) begin
                if (!r.found) begin
                    r.found = 1'b1;
                    r.start = 2'(i);
                    r.len   = 3'd1;
                    open    = 1'b1;
                end else if (open) begin
                    r.len = r.len + 3'd1;
                end
            end else if (r.found) begin
                open = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_ram_shifter.sv
// SCK divider and 8-bit mode-0 shift engine; a load on the done edge chains bytes seamlessly.
module spi_ram_shifter #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       done_o,
    output logic [7:0] rx_byte_o,
    output logic       sck_o,
    output logic       mosi_o
);

    logic        active_q, active_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [6:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        tick;

    assign tick      = (div_q == 16'(CLK_DIV - 1));
    assign done_o    = active_q && sck_q && tick && (bit_q == 3'd0);
    assign rx_byte_o = rx_q;
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;

    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (active_q) begin
            if (!tick) begin
                div_d = div_q + 16'd1;
            end else begin
                div_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[6:0], miso_i};
                end else if (bit_q != 3'd0) begin
                    sck_d  = 1'b0;
                    bit_d  = bit_q - 3'd1;
                    mosi_d = tx_q[6];
                    tx_d   = {tx_q[5:0], 1'b0};
                end else begin
                    sck_d    = 1'b0;
                    mosi_d   = 1'b0;
                    active_d = 1'b0;
                end
            end
        end
        if (load_i) begin
            active_d = 1'b1;
            sck_d    = 1'b0;
            div_d    = '0;
            bit_d    = 3'd7;
            mosi_d   = tx_byte_i[7];
            tx_d     = tx_byte_i[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

endmodule

// File: rtl/spi_ram_controller.sv
// Word read/write bus requests to SPI RAM 0x03/0x02 command transactions, one per strobe run.
module spi_ram_controller
    import spi_ram_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned CS_HIGH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        spi_csb,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_e      state_q, state_d;
    logic        live_q, we_q, we_d, csb_q, csb_d;
    logic [23:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d, idx_q, idx_d;
    logic [1:0]  run_start_q, run_start_d;
    logic [2:0]  run_len_q, run_len_d;
    logic [15:0] cnt_q, cnt_d;

    logic        load, sh_done;
    logic [7:0]  load_byte, next_byte, sh_rx;
    logic [3:0]  nidx, last_idx;
    logic [1:0]  dsel;
    logic [2:0]  run_end;
    run_t        acc_run, gap_run;
    logic        unused_addr;

    assign unused_addr = ^req_addr[1:0];
    assign req_ready   = (state_q == StIdle) && live_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_rdata   = rdata_q;
    assign spi_csb     = csb_q;

    assign nidx     = idx_q + 4'd1;
    assign dsel     = run_start_q + nidx[1:0];
    assign last_idx = we_q ? (4'd3 + {1'b0, run_len_q}) : 4'd7;
    assign run_end  = {1'b0, run_start_q} + run_len_q;
    assign acc_run  = next_run(req_wstrb, 3'd0);
    assign gap_run  = next_run(wstrb_q, run_end);

    always_comb begin
        unique case (nidx)
            4'd1:    next_byte = addr_q[23:16];
            4'd2:    next_byte = addr_q[15:8];
            4'd3:    next_byte = {addr_q[7:2], run_start_q};
            default: next_byte = we_q ? wdata_q[{dsel, 3'b000} +: 8] : 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        idx_d       = idx_q;
        run_start_d = run_start_q;
        run_len_d   = run_len_q;
        cnt_d       = cnt_q;
        csb_d       = csb_q;
        rbuf_d      = rbuf_q;
        rdata_d     = rdata_q;
        load        = 1'b0;
        load_byte   = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (req_valid && live_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr[23:2];
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_we && !acc_run.found) begin
                        state_d = StResp;
                    end else begin
                        state_d     = StShift;
                        csb_d       = 1'b0;
                        load        = 1'b1;
                        load_byte   = req_we ? SPI_CMD_WRITE : SPI_CMD_READ;
                        idx_d       = 4'd0;
                        run_start_d = req_we ? acc_run.start : 2'd0;
                        run_len_d   = acc_run.len;
                    end
                end
            end
            StShift: begin
                if (sh_done) begin
                    // Read data arrives LSB byte first; shift down so byte 0 ends in [7:0].
                    if (!we_q && idx_q >= 4'd4) rbuf_d = {sh_rx, rbuf_q[31:8]};
                    if (idx_q == last_idx) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end else begin
                        load      = 1'b1;
                        load_byte = next_byte;
                        idx_d     = nidx;
                    end
                end
            end
            StHold: begin
                if (cnt_q == 16'(CLK_DIV - 1)) begin
                    csb_d   = 1'b1;
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (cnt_q == 16'(CS_HIGH - 1)) begin
                    if (we_q && gap_run.found) begin
                        state_d     = StShift;
                        csb_d       = 1'b0;
                        load        = 1'b1;
                        load_byte   = SPI_CMD_WRITE;
                        idx_d       = 4'd0;
                        run_start_d = gap_run.start;
                        run_len_d   = gap_run.len;
                    end else begin
                        state_d = StResp;
                        if (!we_q) rdata_d = rbuf_q;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            live_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            idx_q       <= '0;
            run_start_q <= '0;
            run_len_q   <= '0;
            cnt_q       <= '0;
            csb_q       <= 1'b1;
            rbuf_q      <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            idx_q       <= idx_d;
            run_start_q <= run_start_d;
            run_len_q   <= run_len_d;
            cnt_q       <= cnt_d;
            csb_q       <= csb_d;
            rbuf_q      <= rbuf_d;
            rdata_q     <= rdata_d;
        end
    end

    spi_ram_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .tx_byte_i(load_byte),
        .miso_i   (spi_miso),
        .done_o   (sh_done),
        .rx_byte_o(sh_rx),
        .sck_o    (spi_sck),
        .mosi_o   (spi_mosi)
    );

endmodule

// File: tb/tb_spi_ram_controller.sv
// Directed bench: two controllers (CLK_DIV 1 and 3), each with its own behavioural SPI RAM model.
module tb_spi_ram_controller;

    localparam int TMO = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic        req_we = 1'b0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [1:0]  ready_w, rspv_w, csb_w, sck_w, mosi_w;
    wire  [1:0]  miso_w;
    logic [31:0] rdata0, rdata1;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_ram_controller #(.CLK_DIV(1), .CS_HIGH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(ready_w[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rspv_w[0]), .rsp_rdata(rdata0), .spi_csb(csb_w[0]), .spi_sck(sck_w[0]),
        .spi_mosi(mosi_w[0]), .spi_miso(miso_w[0])
    );

    spi_ram_controller #(.CLK_DIV(3), .CS_HIGH(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(ready_w[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rspv_w[1]), .rsp_rdata(rdata1), .spi_csb(csb_w[1]), .spi_sck(sck_w[1]),
        .spi_mosi(mosi_w[1]), .spi_miso(miso_w[1])
    );

    // Mode-0 SPI RAM model, evaluated mid-cycle while DUT outputs are stable.
    for (genvar g = 0; g < 2; g++) begin : g_m
        logic [7:0]  mem [0:1023];
        logic [7:0]  logb [0:511];
        int          gaps [0:63];
        int          nlog = 0, ntrans = 0, bitn = 0, last_low = 0, low_cnt = 0;
        int          gap_cnt = 1000, run = 0, rmin = 0, rmax = 0;
        logic        prev_sck = 1'b0, prev_csb = 1'b1, miso = 1'b0;
        logic [7:0]  sh = '0, cmd = '0, rb;
        logic [23:0] addr = '0, ra;

        assign miso_w[g] = miso;

        always @(negedge clk) begin
            if (!csb_w[g]) begin
                if (prev_csb) begin
                    ntrans++;
                    gaps[ntrans % 64] = gap_cnt;
                    bitn = 0; low_cnt = 0; run = 0; rmin = 1000; rmax = 0; cmd = '0;
                end
                low_cnt++;
                if (sck_w[g] != prev_sck) begin
                    if (run < rmin) rmin = run;
                    if (run > rmax) rmax = run;
                    run = 1;
                end else begin
                    run++;
                end
                if (sck_w[g] && !prev_sck) begin
                    sh = {sh[6:0], mosi_w[g]};
                    bitn++;
                    if (bitn % 8 == 0) begin
                        if (nlog < 512) logb[nlog] = sh;
                        nlog++;
                        case (bitn / 8)
                            1: cmd = sh;
                            2: addr[23:16] = sh;
                            3: addr[15:8] = sh;
                            4: addr[7:0] = sh;
                            default: if (cmd == 8'h02) begin
                                mem[addr[9:0]] = sh;
                                addr = addr + 24'd1;
                            end
                        endcase
                    end
                end else if (!sck_w[g] && prev_sck && cmd == 8'h03 && bitn >= 32) begin
                    ra = addr + 24'((bitn / 8) - 4);
                    rb = mem[ra[9:0]];
                    miso = rb[7 - (bitn % 8)];
                end
            end else begin
                if (!prev_csb) begin
                    last_low = low_cnt;
                    if (run < rmin) rmin = run;
                    if (run > rmax) rmax = run;
                    gap_cnt = 0;
                end
                gap_cnt++;
                bitn = 0;
                miso = 1'b0;
            end
            prev_csb = csb_w[g];
            prev_sck = sck_w[g];
        end
    end

    // Stimulus helper: issue one request on instance g and wait for its response.
    task automatic issue(input int g, input logic we, input logic [23:0] a, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] rd, output int lat);
        int n;
        req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st;
        req_valid[g] = 1'b1;
        n = 0;
        while (!ready_w[g] && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        lat = 0;
        while (!rspv_w[g] && lat < TMO) begin @(posedge clk); #1; lat++; end
        rd = (g == 0) ? rdata0 : rdata1;
        n_checks++;
        if (lat >= TMO) begin
            n_fail++;
            $display("FAIL rsp_timeout: waited %0d cycles, required < %0d", lat, TMO);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (csb_w !== 2'b11) begin n_fail++; $display("FAIL rst_csb: got %b expected 11", csb_w); end
        n_checks++; if (sck_w !== 2'b00) begin n_fail++; $display("FAIL rst_sck: got %b expected 00", sck_w); end
        n_checks++; if (mosi_w !== 2'b00) begin n_fail++; $display("FAIL rst_mosi: got %b expected 00", mosi_w); end
        n_checks++; if (ready_w !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b expected 00", ready_w); end
        n_checks++; if (rspv_w !== 2'b00) begin n_fail++; $display("FAIL rst_rspv: got %b expected 00", rspv_w); end
        n_checks++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", rdata0); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (ready_w !== 2'b00) begin n_fail++; $display("FAIL ready_before_edge: got %b expected 00", ready_w); end
        @(posedge clk); #1;
        n_checks++; if (ready_w !== 2'b11) begin n_fail++; $display("FAIL ready_after_edge: got %b expected 11", ready_w); end
    endtask

    task automatic test_full_word();
        logic [31:0] rd;
        logic [63:0] got;
        int lat, n0, l0;
        n0 = g_m[0].ntrans; l0 = g_m[0].nlog;
        issue(0, 1'b1, 24'h000100, 32'hDEADBEEF, 4'hF, rd, lat);
        got = '0;
        for (int i = 0; i < 8; i++) got = {got[55:0], g_m[0].logb[l0 + i]};
        n_checks++; if (g_m[0].ntrans - n0 !== 1) begin n_fail++; $display("FAIL wr_ntrans: got %0d expected 1", g_m[0].ntrans - n0); end
        n_checks++; if (got !== 64'h02000100EFBEADDE) begin n_fail++; $display("FAIL wr_bytes: got %h expected 02000100efbeadde", got); end
        n_checks++; if (g_m[0].last_low !== 129) begin n_fail++; $display("FAIL wr_csb_low: got %0d expected 129", g_m[0].last_low); end
        n_checks++; if (lat !== 131) begin n_fail++; $display("FAIL wr_latency: got %0d expected 131", lat); end
        @(posedge clk); #1;
        n_checks++; if (rspv_w[0] !== 1'b0) begin n_fail++; $display("FAIL rsp_one_cycle: got %b expected 0", rspv_w[0]); end
        l0 = g_m[0].nlog;
        issue(0, 1'b0, 24'h000100, 32'h0, 4'h0, rd, lat);
        got = '0;
        for (int i = 0; i < 4; i++) got = {got[55:0], g_m[0].logb[l0 + i]};
        n_checks++; if (got[31:0] !== 32'h03000100) begin n_fail++; $display("FAIL rd_cmd: got %h expected 03000100", got[31:0]); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        n_checks++; if (g_m[0].last_low !== 129) begin n_fail++; $display("FAIL rd_csb_low: got %0d expected 129", g_m[0].last_low); end
    endtask

    task automatic test_strobe_runs();
        logic [31:0] rd;
        logic [79:0] got;
        int lat, n0, l0;
        issue(0, 1'b1, 24'h000200, 32'hAAAAAAAA, 4'hF, rd, lat);
        n0 = g_m[0].ntrans; l0 = g_m[0].nlog;
        issue(0, 1'b1, 24'h000200, 32'h11223344, 4'b0101, rd, lat);
        got = '0;
        for (int i = 0; i < 10; i++) got = {got[71:0], g_m[0].logb[l0 + i]};
        n_checks++; if (g_m[0].ntrans - n0 !== 2) begin n_fail++; $display("FAIL run_ntrans: got %0d expected 2", g_m[0].ntrans - n0); end
        n_checks++; if (got !== 80'h02000200440200020222) begin n_fail++; $display("FAIL run_bytes: got %h expected 02000200440200020222", got); end
        n_checks++; if (g_m[0].gaps[(n0 + 2) % 64] !== 2) begin n_fail++; $display("FAIL run_gap: got %0d expected 2", g_m[0].gaps[(n0 + 2) % 64]); end
        n_checks++; if (g_m[0].last_low !== 81) begin n_fail++; $display("FAIL run_csb_low: got %0d expected 81", g_m[0].last_low); end
        n_checks++; if (lat !== 166) begin n_fail++; $display("FAIL run_latency: got %0d expected 166", lat); end
        issue(0, 1'b0, 24'h000200, 32'h0, 4'h0, rd, lat);
        n_checks++; if (rd !== 32'hAA22AA44) begin n_fail++; $display("FAIL run_readback: got %h expected aa22aa44", rd); end
    endtask

    task automatic test_zero_strobe();
        logic [31:0] rd;
        int lat, n0;
        n0 = g_m[0].ntrans;
        issue(0, 1'b1, 24'h000100, 32'h55555555, 4'h0, rd, lat);
        n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL zs_latency: got %0d expected 0", lat); end
        n_checks++; if (g_m[0].ntrans !== n0) begin n_fail++; $display("FAIL zs_no_csb: got %0d expected %0d", g_m[0].ntrans, n0); end
        n_checks++; if (rdata0 !== 32'hAA22AA44) begin n_fail++; $display("FAIL zs_rdata_hold: got %h expected aa22aa44", rdata0); end
        issue(0, 1'b0, 24'h000100, 32'h0, 4'h0, rd, lat);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zs_mem_unchanged: got %h expected deadbeef", rd); end
    endtask

    task automatic test_clk_div3();
        logic [31:0] rd;
        logic [31:0] got;
        int lat, l0;
        issue(1, 1'b1, 24'h000100, 32'hCAFEF00D, 4'hF, rd, lat);
        n_checks++; if (g_m[1].last_low !== 387) begin n_fail++; $display("FAIL div3_csb_low: got %0d expected 387", g_m[1].last_low); end
        l0 = g_m[1].nlog;
        issue(1, 1'b0, 24'h000103, 32'h0, 4'h0, rd, lat);
        got = '0;
        for (int i = 0; i < 4; i++) got = {got[23:0], g_m[1].logb[l0 + i]};
        n_checks++; if (got !== 32'h03000100) begin n_fail++; $display("FAIL div3_cmd: got %h expected 03000100", got); end
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL div3_data: got %h expected cafef00d", rd); end
        n_checks++; if (g_m[1].rmin !== 3 || g_m[1].rmax !== 3) begin
            n_fail++; $display("FAIL div3_half_period: got min %0d max %0d expected 3", g_m[1].rmin, g_m[1].rmax);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        int lat, n, pulses;
        req_we = 1'b0; req_addr = 24'h000200; req_wstrb = 4'h0;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (g_m[0].bitn < 20 && n < 500) begin @(posedge clk); #1; n++; end
        n_checks++; if (g_m[0].bitn !== 20) begin n_fail++; $display("FAIL abort_reach_bit20: got %0d expected 20", g_m[0].bitn); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (csb_w[0] !== 1'b1) begin n_fail++; $display("FAIL abort_csb: got %b expected 1", csb_w[0]); end
        n_checks++; if (sck_w[0] !== 1'b0) begin n_fail++; $display("FAIL abort_sck: got %b expected 0", sck_w[0]); end
        n_checks++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL abort_rdata: got %h expected 0", rdata0); end
        pulses = 0;
        repeat (2) begin @(posedge clk); #1; if (rspv_w[0]) pulses++; end
        rst_n = 1'b1;
        repeat (300) begin @(posedge clk); #1; if (rspv_w[0]) pulses++; end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d pulses expected 0", pulses); end
        issue(0, 1'b0, 24'h000200, 32'h0, 4'h0, rd, lat);
        n_checks++; if (rd !== 32'hAA22AA44) begin n_fail++; $display("FAIL abort_reread: got %h expected aa22aa44", rd); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] addrs [3];
        logic [31:0] exps [3];
        int n0, acc, rsp, cyc, busy_ready;
        logic rdy;
        addrs = '{24'h000200, 24'h000100, 24'h000200};
        exps  = '{32'hAA22AA44, 32'hDEADBEEF, 32'hAA22AA44};
        n0 = g_m[0].ntrans;
        acc = 0; rsp = 0; cyc = 0; busy_ready = 0;
        req_we = 1'b0; req_wstrb = 4'h0; req_addr = addrs[0];
        req_valid[0] = 1'b1;
        while (rsp < 3 && cyc < TMO) begin
            rdy = ready_w[0];
            @(posedge clk); #1;
            cyc++;
            if (rdy && req_valid[0]) begin
                acc++;
                if (acc == 3) req_valid[0] = 1'b0;
                else req_addr = addrs[acc];
            end
            if (ready_w[0] && !csb_w[0]) busy_ready++;
            if (rspv_w[0]) begin
                n_checks++; if (rdata0 !== exps[rsp]) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", rsp, rdata0, exps[rsp]); end
                n_checks++; if (ready_w[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_resp%0d: got %b expected 0", rsp, ready_w[0]); end
                rsp++;
            end
        end
        req_valid[0] = 1'b0;
        n_checks++; if (rsp !== 3) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d expected 3", rsp); end
        n_checks++; if (busy_ready !== 0) begin n_fail++; $display("FAIL b2b_ready_busy: got %0d cycles expected 0", busy_ready); end
        n_checks++; if (g_m[0].ntrans - n0 !== 3) begin n_fail++; $display("FAIL b2b_ntrans: got %0d expected 3", g_m[0].ntrans - n0); end
        n_checks++; if (g_m[0].gaps[(n0 + 2) % 64] !== 4 || g_m[0].gaps[(n0 + 3) % 64] !== 4) begin
            n_fail++; $display("FAIL b2b_gap: got %0d,%0d expected 4,4", g_m[0].gaps[(n0 + 2) % 64], g_m[0].gaps[(n0 + 3) % 64]);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_strobe_runs();
        test_zero_strobe();
        test_clk_div3();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
